// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM encoding,
// counter sizing and the single-bit full-adder cell used by the ripple slice.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter must be able to hold STEPS itself, since it increments on the last step too
  function automatic int cnt_width(input int steps);
    return $clog2(steps + 1);
  endfunction

  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    logic [1:0] r;
    r[0] = x ^ y ^ c;
    r[1] = (x & y) | (c & (x ^ y));
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// Combinational DIGIT-bit ripple slice built from chained full-adder cells.
// Also exposes the carry into the top bit for signed-overflow detection.
module digit_adder
  import serial_adder_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] c_s;

  assign c_s[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign {c_s[i+1], s[i]} = full_add(x[i], y[i], c_s[i]);
  end

  assign co    = c_s[DIGIT];
  assign c_msb = c_s[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands consumed DIGIT bits per clock
// through one ripple slice, with a start/busy/done handshake.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = cnt_width(STEPS);

  localparam logic [1:0]    IDLE = ST_IDLE;
  localparam logic [1:0]    RUN  = ST_RUN;
  localparam logic [1:0]    DONE = ST_DONE;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_adder: DIGIT (%0d) must divide WIDTH (%0d)", DIGIT, WIDTH);
  end

  logic [1:0]             state_r;
  logic [WIDTH-1:0]       a_r;
  logic [WIDTH-1:0]       b_r;
  logic [WIDTH-1:0]       sum_r;
  logic [CW-1:0]          cnt_r;
  logic                   carry_r;
  logic                   cout_r;
  logic                   ovf_r;
  logic                   busy_r;
  logic                   done_r;

  logic [DIGIT-1:0]       slice_sum_s;
  logic                   slice_co_s;
  logic                   slice_cmsb_s;
  logic [WIDTH+DIGIT-1:0] sum_cat_s;
  logic                   accept_s;
  logic                   last_s;

  digit_adder #(.DIGIT(DIGIT)) u_slice (
    .x     (a_r[DIGIT-1:0]),
    .y     (b_r[DIGIT-1:0]),
    .ci    (carry_r),
    .s     (slice_sum_s),
    .co    (slice_co_s),
    .c_msb (slice_cmsb_s)
  );

  // New digits enter at the MSB end; this form also works when DIGIT == WIDTH
  assign sum_cat_s = {slice_sum_s, sum_r};
  assign accept_s  = start && ((state_r == IDLE) || (state_r == DONE));
  assign last_s    = (cnt_r == LAST);

  // FSM, operand shift registers, carry flop and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      cnt_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (accept_s) begin
            // Subtraction runs as a + ~b + ~cin
            a_r     <= a;
            b_r     <= b ^ {WIDTH{sub}};
            carry_r <= cin ^ sub;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          sum_r   <= sum_cat_s[WIDTH+DIGIT-1:DIGIT];
          carry_r <= slice_co_s;
          a_r     <= a_r >> DIGIT;
          b_r     <= b_r >> DIGIT;
          cnt_r   <= cnt_r + CW'(1);
          if (last_s) begin
            cout_r  <= slice_co_s;
            ovf_r   <= slice_cmsb_s ^ slice_co_s;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            state_r <= RUN;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: three instances (8/1, 8/4, 4/2) sharing clock
// and reset; expected results are queued at issue time and popped on done.
module tb_serial_adder;

  typedef struct {
    logic [7:0] s;
    logic       co;
    logic       ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  logic       start0 = 1'b0, cin0 = 1'b0, sub0 = 1'b0;
  logic [7:0] a0 = 8'h00, b0 = 8'h00;
  logic       busy0, done0, cout0, ovf0;
  logic [7:0] sum0;

  logic       start1 = 1'b0, cin1 = 1'b0, sub1 = 1'b0;
  logic [7:0] a1 = 8'h00, b1 = 8'h00;
  logic       busy1, done1, cout1, ovf1;
  logic [7:0] sum1;

  logic       start2 = 1'b0, cin2 = 1'b0, sub2 = 1'b0;
  logic [3:0] a2 = 4'h0, b2 = 4'h0;
  logic       busy2, done2, cout2, ovf2;
  logic [3:0] sum2;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .cin(cin0), .sub(sub0),
    .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .ovf(ovf0));

  serial_adder #(.WIDTH(8), .DIGIT(4)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1), .sub(sub1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1));

  serial_adder #(.WIDTH(4), .DIGIT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2), .sub(sub2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2));

  // Integer reference: unsigned result for sum/carry, signed range test for overflow
  function automatic exp_t model(input int w, input int a, input int b, input int cin, input int sub);
    exp_t e;
    int m, r, sa, sb, sr;
    m  = 1 << w;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    if (sub != 0) begin
      r    = a - b - cin;
      e.co = (r >= 0);
      sr   = sa - sb - cin;
    end else begin
      r    = a + b + cin;
      e.co = (r >= m);
      sr   = sa + sb + cin;
    end
    e.s  = 8'(((r % m) + m) % m);
    e.ov = (sr < -(m / 2)) || (sr > (m / 2 - 1));
    return e;
  endfunction

  // Called at a negedge: drive one start cycle on dut0, queue the expectation
  task automatic issue0(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s, input exp_t e);
    a0 = a; b0 = b; cin0 = c; sub0 = s; start0 = 1'b1;
    q0.push_back(e);
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic wait0(output int cyc, output int bc);
    cyc = 0; bc = 0;
    while (!done0 && cyc < 40) begin
      if (busy0) bc++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if ({busy0, done0, sum0, cout0, ovf0} !== 12'h000) begin
      errors++; $display("FAIL reset_dut0: got %h expected 000", {busy0, done0, sum0, cout0, ovf0});
    end
    checks++;
    if ({busy1, done1, sum1, cout1, ovf1} !== 12'h000) begin
      errors++; $display("FAIL reset_dut1: got %h expected 000", {busy1, done1, sum1, cout1, ovf1});
    end
    checks++;
    if ({busy2, done2, sum2, cout2, ovf2} !== 8'h00) begin
      errors++; $display("FAIL reset_dut2: got %h expected 00", {busy2, done2, sum2, cout2, ovf2});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add_sub();
    logic [27:0] vec [5];
    exp_t e;
    int cyc, bc;
    vec = '{{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0},
            {8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0},
            {8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1},
            {8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0},
            {8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1}};
    for (int i = 0; i < 5; i++) begin
      issue0(vec[i][27:20], vec[i][19:12], vec[i][11], vec[i][10],
             exp_t'{vec[i][9:2], vec[i][1], vec[i][0]});
      wait0(cyc, bc);
      checks++;
      if (cyc !== 8) begin
        errors++; $display("FAIL latency_%0d: got %0d expected 8", i, cyc);
      end
      checks++;
      if (bc !== 8) begin
        errors++; $display("FAIL busy_len_%0d: got %0d expected 8", i, bc);
      end
      e = q0.pop_front();
      checks++;
      if ({sum0, cout0, ovf0} !== {e.s, e.co, e.ov}) begin
        errors++; $display("FAIL result_%0d: got %h/%b/%b expected %h/%b/%b", i, sum0, cout0, ovf0, e.s, e.co, e.ov);
      end
      @(negedge clk);
      checks++;
      if (done0 !== 1'b0) begin
        errors++; $display("FAIL done_pulse_%0d: got %b expected 0", i, done0);
      end
    end
  endtask

  task automatic test_ignore_and_back_to_back();
    exp_t e;
    int cyc, bc;
    issue0(8'h0F, 8'h01, 1'b0, 1'b0, exp_t'{8'h10, 1'b0, 1'b0});
    @(negedge clk);
    a0 = 8'h22; b0 = 8'h11; sub0 = 1'b1; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait0(cyc, bc);
    e = q0.pop_front();
    checks++;
    if (done0 !== 1'b1 || {sum0, cout0, ovf0} !== {e.s, e.co, e.ov}) begin
      errors++; $display("FAIL ignore_start: got done=%b %h/%b/%b expected done=1 %h/%b/%b", done0, sum0, cout0, ovf0, e.s, e.co, e.ov);
    end
    // Still in the DONE cycle: this start must be taken
    issue0(8'h33, 8'h44, 1'b1, 1'b0, exp_t'{8'h78, 1'b0, 1'b0});
    checks++;
    if ({busy0, done0} !== 2'b10) begin
      errors++; $display("FAIL b2b_accept: got busy/done %b expected 10", {busy0, done0});
    end
    wait0(cyc, bc);
    checks++;
    if (cyc !== 8) begin
      errors++; $display("FAIL b2b_latency: got %0d expected 8", cyc);
    end
    e = q0.pop_front();
    checks++;
    if ({sum0, cout0, ovf0} !== {e.s, e.co, e.ov}) begin
      errors++; $display("FAIL b2b_result: got %h/%b/%b expected %h/%b/%b", sum0, cout0, ovf0, e.s, e.co, e.ov);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    int cyc, bc, dcount;
    issue0(8'hFF, 8'h00, 1'b0, 1'b0, exp_t'{8'hFF, 1'b0, 1'b0});
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy0, done0, sum0, cout0, ovf0} !== 12'h000) begin
      errors++; $display("FAIL mid_reset: got %h expected 000", {busy0, done0, sum0, cout0, ovf0});
    end
    q0.delete();
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done0) dcount++;
    end
    checks++;
    if (dcount !== 0) begin
      errors++; $display("FAIL no_done_after_reset: got %0d pulses expected 0", dcount);
    end
    issue0(8'h03, 8'h04, 1'b0, 1'b0, exp_t'{8'h07, 1'b0, 1'b0});
    wait0(cyc, bc);
    e = q0.pop_front();
    checks++;
    if (cyc !== 8 || {sum0, cout0, ovf0} !== {e.s, e.co, e.ov}) begin
      errors++; $display("FAIL post_reset: got cyc=%0d %h/%b/%b expected cyc=8 %h/%b/%b", cyc, sum0, cout0, ovf0, e.s, e.co, e.ov);
    end
    @(negedge clk);
  endtask

  task automatic test_digit4();
    exp_t e;
    int cyc;
    a1 = 8'h7F; b1 = 8'h01; cin1 = 1'b0; sub1 = 1'b0; start1 = 1'b1;
    q1.push_back(exp_t'{8'h80, 1'b0, 1'b1});
    @(negedge clk);
    start1 = 1'b0;
    cyc = 0;
    while (!done1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc !== 2) begin
      errors++; $display("FAIL d4_latency: got %0d expected 2", cyc);
    end
    e = q1.pop_front();
    checks++;
    if ({sum1, cout1, ovf1} !== {e.s, e.co, e.ov}) begin
      errors++; $display("FAIL d4_result: got %h/%b/%b expected %h/%b/%b", sum1, cout1, ovf1, e.s, e.co, e.ov);
    end
    @(negedge clk);
  endtask

  task automatic test_exhaustive_w4();
    exp_t e;
    int cyc;
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < 2; c++) begin
        for (int x = 0; x < 16; x++) begin
          for (int y = 0; y < 16; y++) begin
            a2 = 4'(x); b2 = 4'(y); cin2 = 1'(c); sub2 = 1'(s); start2 = 1'b1;
            q2.push_back(model(4, x, y, c, s));
            @(negedge clk);
            start2 = 1'b0;
            cyc = 0;
            while (!done2 && cyc < 20) begin
              @(negedge clk);
              cyc++;
            end
            e = q2.pop_front();
            checks++;
            if (done2 !== 1'b1 || {sum2, cout2, ovf2} !== {e.s[3:0], e.co, e.ov}) begin
              errors++;
              $display("FAIL w4_%s_a%0d_b%0d_c%0d: got done=%b %h/%b/%b expected done=1 %h/%b/%b",
                       (s != 0) ? "sub" : "add", x, y, c, done2, sum2, cout2, ovf2, e.s[3:0], e.co, e.ov);
            end
          end
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_ignore_and_back_to_back();
    test_reset_mid_run();
    test_digit4();
    test_exhaustive_w4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
